// File: rtl/rx_sync_window.sv
// Synchronizes rxbit, shifts decided bits into a 64-bit window on p_1us, and freezes the window on a correlator trigger edge.
// rxbit reaches the decision 3 clk_6M after it settles; all outputs are registered. RX_MAJORITY_VOTE_EN selects a 2-of-3 sample vote.
module rx_sync_window (
   input  logic        clk_6M,
   input  logic        rstz,
   input  logic        p_1us,
   input  logic        rxbit,
   input  logic        correWindow,
   input  logic        pscorr_trgp,
   output logic [63:0] sync_in,
   output logic        sync_valid,
   output logic [63:0] sync_capt,
   output logic        capt_valid,
   output logic [6:0]  fill_cnt,
   output logic        rxbit_s
);

   typedef enum logic [1:0] {IDLE, FILL, HUNT, HOLD} state_t;

   state_t      state_q, state_d;
   logic        rx_meta_q, rx_sync_q, trig_dly_q, rxbit_s_q;
   logic [63:0] sync_in_q, sync_in_d;
   logic [63:0] sync_capt_q, sync_capt_d;
   logic        sync_valid_q, sync_valid_d;
   logic        capt_valid_q, capt_valid_d;
   logic [6:0]  fill_cnt_q, fill_cnt_d;
   logic        decided_bit;
   logic        trig_rise;

`ifdef RX_MAJORITY_VOTE_EN
   logic [2:0] hist_q;

   always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) hist_q <= 3'b000;
      else       hist_q <= {hist_q[1:0], rx_sync_q};
   end

   assign decided_bit = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);
`else
   logic hist_q;

   always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) hist_q <= 1'b0;
      else       hist_q <= rx_sync_q;
   end

   assign decided_bit = hist_q;
`endif

   assign trig_rise = pscorr_trgp & ~trig_dly_q;

   always_ff @(posedge clk_6M or negedge rstz) begin
      if (!rstz) begin
         rx_meta_q    <= 1'b0;
         rx_sync_q    <= 1'b0;
         trig_dly_q   <= 1'b0;
         rxbit_s_q    <= 1'b0;
         state_q      <= IDLE;
         sync_in_q    <= '0;
         sync_capt_q  <= '0;
         sync_valid_q <= 1'b0;
         capt_valid_q <= 1'b0;
         fill_cnt_q   <= '0;
      end else begin
         rx_meta_q    <= rxbit;
         rx_sync_q    <= rx_meta_q;
         trig_dly_q   <= pscorr_trgp;
         if (p_1us) rxbit_s_q <= decided_bit;
         state_q      <= state_d;
         sync_in_q    <= sync_in_d;
         sync_capt_q  <= sync_capt_d;
         sync_valid_q <= sync_valid_d;
         capt_valid_q <= capt_valid_d;
         fill_cnt_q   <= fill_cnt_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      sync_in_d    = sync_in_q;
      sync_capt_d  = sync_capt_q;
      sync_valid_d = sync_valid_q;
      capt_valid_d = capt_valid_q;
      fill_cnt_d   = fill_cnt_q;
      case (state_q)
         IDLE: begin
            fill_cnt_d   = '0;
            sync_valid_d = 1'b0;
            // Opening clears the window; a strobe landing on this cycle is lost.
            if (correWindow) begin
               state_d      = FILL;
               sync_in_d    = '0;
               capt_valid_d = 1'b0;
            end
         end
         default: begin
            if (!correWindow) begin
               state_d      = IDLE;
               sync_valid_d = 1'b0;
               fill_cnt_d   = '0;
            end else begin
               if (p_1us) begin
                  sync_in_d = {decided_bit, sync_in_q[63:1]};
                  if (fill_cnt_q != 7'd64) fill_cnt_d = fill_cnt_q + 7'd1;
               end
               if (state_q == FILL && p_1us && fill_cnt_q == 7'd63) begin
                  state_d      = HUNT;
                  sync_valid_d = 1'b1;
               end
               // Capture the window as it stood before this cycle's shift.
               if (state_q == HUNT && trig_rise) begin
                  state_d      = HOLD;
                  sync_capt_d  = sync_in_q;
                  capt_valid_d = 1'b1;
               end
            end
         end
      endcase
   end

   assign sync_in    = sync_in_q;
   assign sync_valid = sync_valid_q;
   assign sync_capt  = sync_capt_q;
   assign capt_valid = capt_valid_q;
   assign fill_cnt   = fill_cnt_q;
   assign rxbit_s    = rxbit_s_q;

endmodule

// File: tb/tb_rx_sync_window.sv
// Bench for rx_sync_window: a bit-queue model checked every cycle, plus directed literal checks.
module tb_rx_sync_window;

   logic        clk_6M, rstz, p_1us, rxbit, correWindow, pscorr_trgp;
   logic [63:0] sync_in, sync_capt;
   logic        sync_valid, capt_valid, rxbit_s;
   logic [6:0]  fill_cnt;

   int total = 0;
   int bad   = 0;
   int ph    = 0;
   bit chk_en = 0;

   localparam logic [63:0] PAT1 = 64'hA5A5_0F0F_1234_5678;
   localparam logic [63:0] PAT3 = 64'h0123_4567_89AB_CDEF;

   rx_sync_window dut (
      .clk_6M      (clk_6M),
      .rstz        (rstz),
      .p_1us       (p_1us),
      .rxbit       (rxbit),
      .correWindow (correWindow),
      .pscorr_trgp (pscorr_trgp),
      .sync_in     (sync_in),
      .sync_valid  (sync_valid),
      .sync_capt   (sync_capt),
      .capt_valid  (capt_valid),
      .fill_cnt    (fill_cnt),
      .rxbit_s     (rxbit_s)
   );

   initial begin
      clk_6M = 0;
      forever #5 clk_6M = ~clk_6M;
   end

   // ph is the phase of the upcoming edge; the strobe lands on phase 5.
   initial begin
      p_1us = 0;
      forever begin
         @(posedge clk_6M);
         #1;
         ph    = (ph == 5) ? 0 : ph + 1;
         p_1us = (ph == 5);
      end
   end

   // Model: the window is simply the last 64 decided bits received since it opened.
   bit          m_open, m_got, m_cv, m_rxb, trg_prev;
   int          m_n;
   logic [63:0] m_capt;
   bit          m_q[$];
   bit          smp[$];

   function automatic logic [63:0] m_window();
      logic [63:0] w = '0;
      int sz = m_q.size();
      for (int i = 0; i < sz; i++) w[64 - sz + i] = m_q[i];
      return w;
   endfunction

   task automatic model_step();
      bit dec, rise;
      if (!rstz) begin
         m_open = 0; m_got = 0; m_cv = 0; m_rxb = 0; trg_prev = 0;
         m_n = 0; m_capt = '0;
         m_q.delete();
         smp = '{0, 0, 0, 0, 0};
      end else begin
         // smp[4] is the sample taken one edge ago; the decision sees samples 3..5 edges old.
`ifdef RX_MAJORITY_VOTE_EN
         dec = (smp[2] + smp[1] + smp[0]) >= 2;
`else
         dec = smp[2];
`endif
         rise     = pscorr_trgp && !trg_prev;
         trg_prev = pscorr_trgp;
         if (p_1us) m_rxb = dec;
         if (!m_open) begin
            if (correWindow) begin
               m_open = 1; m_n = 0; m_cv = 0; m_got = 0;
               m_q.delete();
            end
         end else if (!correWindow) begin
            m_open = 0;
         end else begin
            if (rise && m_n >= 64 && !m_got) begin
               m_capt = m_window(); m_cv = 1; m_got = 1;
            end
            if (p_1us) begin
               m_q.push_back(dec);
               if (m_q.size() > 64) void'(m_q.pop_front());
               m_n++;
            end
         end
         smp.push_back(rxbit);
         void'(smp.pop_front());
      end
   endtask

   initial forever begin
      @(posedge clk_6M or negedge rstz);
      model_step();
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   initial forever begin
      @(negedge clk_6M);
      if (chk_en) begin
         chk("m_sync_in",    sync_in,    m_window());
         chk("m_sync_valid", sync_valid, m_open && m_n >= 64);
         chk("m_sync_capt",  sync_capt,  m_capt);
         chk("m_capt_valid", capt_valid, m_cv);
         chk("m_fill_cnt",   fill_cnt,   m_open ? ((m_n > 64) ? 64 : m_n) : 0);
         chk("m_rxbit_s",    rxbit_s,    m_rxb);
      end
   end

   task automatic tick();
      @(posedge clk_6M);
      #2;
   endtask

   task automatic wait_strobe_consumed();
      int n = 0;
      while (!p_1us && n < 12) begin tick(); n++; end
      if (!p_1us) begin
         total++; bad++;
         $display("FAIL strobe_wait: no p_1us within %0d cycles", n);
      end
      tick();
   endtask

   task automatic glitch(input bit b);
      int n = 0;
      bit nb = ~b;
      rxbit = b;
      wait_strobe_consumed();
      while (ph != 2 && n < 12) begin tick(); n++; end
      rxbit = nb;
      tick();
      rxbit = b;
      wait_strobe_consumed();
`ifdef RX_MAJORITY_VOTE_EN
      chk("glitch_vote", rxbit_s, b);
`else
      chk("glitch_newest", rxbit_s, nb);
`endif
   endtask

   task automatic fill(input logic [63:0] pat, input bit trig_pulse);
      for (int i = 0; i < 64; i++) begin
         rxbit = pat[i];
         if (trig_pulse) pscorr_trgp = (i == 30 || i == 31);
         wait_strobe_consumed();
         if (i == 62) begin
            chk("fill63_cnt",   fill_cnt,   63);
            chk("fill63_valid", sync_valid, 0);
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rstz = 0; rxbit = 0; correWindow = 0; pscorr_trgp = 0;
      repeat (3) tick();
      chk("rst_sync_in",    sync_in,    0);
      chk("rst_sync_capt",  sync_capt,  0);
      chk("rst_sync_valid", sync_valid, 0);
      chk("rst_capt_valid", capt_valid, 0);
      chk("rst_fill_cnt",   fill_cnt,   0);
      chk("rst_rxbit_s",    rxbit_s,    0);
      chk_en = 1;
      rstz = 1;
      repeat (4) tick();

      glitch(1);
      glitch(0);

      // First window: LSB-first pattern, with a trigger pulse during FILL.
      correWindow = 1;
      fill(PAT1, 1);
      chk("fill_sync_in",    sync_in,    PAT1);
      chk("fill_cnt64",      fill_cnt,   64);
      chk("fill_valid",      sync_valid, 1);
      chk("fill_no_capt",    capt_valid, 0);
      chk("fill_rxbit_s",    rxbit_s,    1);

      // Long trigger in HUNT: exactly one capture of the pre-shift window.
      pscorr_trgp = 1;
      tick();
      chk("hunt_capt",       sync_capt,  PAT1);
      chk("hunt_capt_valid", capt_valid, 1);
      repeat (5) tick();
      pscorr_trgp = 0;
      for (int i = 0; i < 600; i++) begin
         rxbit = 1'($urandom_range(0, 1));
         tick();
      end
      pscorr_trgp = 1;
      repeat (3) tick();
      pscorr_trgp = 0;
      tick();
      chk("hold_capt_kept",  sync_capt,  PAT1);
      chk("hold_capt_valid", capt_valid, 1);
      chk("hold_valid",      sync_valid, 1);
      chk("hold_fill_sat",   fill_cnt,   64);

      // Close then reopen on the next cycle.
      correWindow = 0;
      tick();
      chk("close_valid",      sync_valid, 0);
      chk("close_capt_valid", capt_valid, 1);
      chk("close_fill",       fill_cnt,   0);
      correWindow = 1;
      tick();
      chk("reopen_capt_valid", capt_valid, 0);
      chk("reopen_sync_in",    sync_in,    0);
      chk("reopen_fill",       fill_cnt,   0);
      for (int i = 0; i < 64; i++) begin
         rxbit = 1'($urandom_range(0, 1));
         wait_strobe_consumed();
      end
      chk("fill2_valid", sync_valid, 1);

      // Window closes on the trigger's rising edge: close wins.
      correWindow = 0;
      pscorr_trgp = 1;
      tick();
      chk("closetrg_capt_valid", capt_valid, 0);
      chk("closetrg_valid",      sync_valid, 0);
      chk("closetrg_capt",       sync_capt,  PAT1);
      repeat (3) tick();
      pscorr_trgp = 0;

      // Open on a strobe cycle: that strobe is dropped.
      n = 0;
      while (ph != 5 && n < 12) begin tick(); n++; end
      correWindow = 1;
      tick();
      chk("open_strobe_fill",    fill_cnt, 0);
      chk("open_strobe_sync_in", sync_in,  0);
      fill(PAT3, 0);
      chk("fill3_sync_in", sync_in,    PAT3);
      chk("fill3_valid",   sync_valid, 1);
      pscorr_trgp = 1;
      tick();
      chk("fill3_capt", sync_capt, PAT3);

      // Asynchronous reset mid-HOLD.
      #1;
      rstz = 0;
      #1;
      chk("arst_sync_in",    sync_in,    0);
      chk("arst_sync_capt",  sync_capt,  0);
      chk("arst_sync_valid", sync_valid, 0);
      chk("arst_capt_valid", capt_valid, 0);
      chk("arst_fill_cnt",   fill_cnt,   0);
      chk("arst_rxbit_s",    rxbit_s,    0);
      pscorr_trgp = 0;
      correWindow = 0;
      repeat (3) tick();
      rstz = 1;
      repeat (5) tick();
      chk("post_rst_capt_valid", capt_valid, 0);
      chk("post_rst_fill",       fill_cnt,   0);
      chk("post_rst_valid",      sync_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
